// File: rtl/uart_word_assembler_pkg.sv
// Shared constants, state encoding and timeout derivation for the UART word assembler.
package uart_word_assembler_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_IDX_W = 2;
  localparam int TIMER_W    = 32;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_CLOCK_FREQUENCY = 50000000;

  // A session ends after 100 ms of byte silence.
  function automatic int unsigned timeout_cycles_for(input int unsigned freq_hz);
    return freq_hz / 10;
  endfunction

  localparam int unsigned DEFAULT_IDLE_TIMEOUT_CYCLES =
    timeout_cycles_for(DEFAULT_CLOCK_FREQUENCY);

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: reloads on every accepted byte, counts down while a
// session is running and flags expiry in the cycle the count sits at 1 with
// no byte arriving.
module uart_idle_timer
  import uart_word_assembler_pkg::*;
#(
  parameter logic [TIMER_W-1:0] load_value = DEFAULT_IDLE_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  input  logic abort,
  output logic expire
);

  logic [TIMER_W-1:0] count;

  // Expiry: last count of the window, no byte this cycle, no abort overriding it.
  always_comb begin
    expire = run && !load && !abort && (count == TIMER_W'(1));
  end

  // Counter: cleared when the session ends, reloaded on a byte, else counts down.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (abort || expire) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs received UART bytes little-endian into 32-bit words and emits one
// word write per four bytes. A byte-silence timeout or clear ends the session,
// dropping any partial word and restarting the word address at 0.
//
// Interface semantics: byte_ready is a one-cycle strobe qualifying byte_data.
// word_valid is a one-cycle strobe qualifying word_addr/word_data; there is no
// ready/backpressure, so the sink must take every strobe. partial_drop is a
// one-cycle strobe and is never high together with word_valid.
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int unsigned clock_frequency     = DEFAULT_CLOCK_FREQUENCY,
  parameter int unsigned idle_timeout_cycles = timeout_cycles_for(clock_frequency),
  parameter int          addr_width          = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            byte_data,
  input  logic                  byte_ready,
  input  logic                  clear,
  output logic                  word_valid,
  output logic [addr_width-1:0] word_addr,
  output logic [31:0]           word_data,
  output logic                  loading,
  output logic                  partial_drop
);

  state_t                  state;
  state_t                  next_state;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  logic [2:0][7:0]         lanes;
  logic [addr_width-1:0]   addr;
  logic                    accept;
  logic                    word_done;
  logic                    expire;

  uart_idle_timer #(
    .load_value(TIMER_W'(idle_timeout_cycles))
  ) u_idle_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (accept),
    .run    (state == ST_COLLECT),
    .abort  (clear),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a byte opens a session; clear or silence closes it.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept) next_state = ST_COLLECT;
      ST_COLLECT: if (clear || expire) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Control decode: clear discards any byte in its cycle.
  always_comb begin
    accept    = byte_ready && !clear;
    word_done = accept && (byte_idx == BYTE_IDX_W'(WORD_BYTES - 1));
    loading   = (state == ST_COLLECT);
  end

  // Byte lanes, byte index, address counter and output strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx     <= '0;
      lanes        <= '0;
      addr         <= '0;
      word_valid   <= 1'b0;
      word_addr    <= '0;
      word_data    <= '0;
      partial_drop <= 1'b0;
    end else begin
      word_valid   <= 1'b0;
      partial_drop <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        addr     <= '0;
      end else if (accept) begin
        byte_idx <= byte_idx + BYTE_IDX_W'(1);
        case (byte_idx)
          2'd0:    lanes[0] <= byte_data;
          2'd1:    lanes[1] <= byte_data;
          2'd2:    lanes[2] <= byte_data;
          default: ;
        endcase
        if (word_done) begin
          word_valid <= 1'b1;
          word_addr  <= addr;
          word_data  <= {byte_data, lanes[2], lanes[1], lanes[0]};
          addr       <= addr + addr_width'(1);
        end
      end else if (expire) begin
        byte_idx     <= '0;
        addr         <= '0;
        partial_drop <= (byte_idx != '0);
      end
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: two instances (16-bit and 2-bit address)
// share one stimulus stream and are checked every cycle against a
// byte-queue/timestamp reference model, plus a hand-written vector table and
// directed corner-case sequences.
module tb_uart_word_assembler;

  localparam int T = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        clear;

  logic        a_valid, a_loading, a_drop;
  logic [15:0] a_addr;
  logic [31:0] a_data;
  logic        b_valid, b_loading, b_drop;
  logic [1:0]  b_addr;
  logic [31:0] b_data;

  always #5 clock = ~clock;

  uart_word_assembler #(
    .clock_frequency(50000000), .idle_timeout_cycles(T), .addr_width(16)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .byte_data(byte_data),
    .byte_ready(byte_ready), .clear(clear), .word_valid(a_valid),
    .word_addr(a_addr), .word_data(a_data), .loading(a_loading),
    .partial_drop(a_drop)
  );

  uart_word_assembler #(
    .clock_frequency(50000000), .idle_timeout_cycles(T), .addr_width(2)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .byte_data(byte_data),
    .byte_ready(byte_ready), .clear(clear), .word_valid(b_valid),
    .word_addr(b_addr), .word_data(b_data), .loading(b_loading),
    .partial_drop(b_drop)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int words_a = 0;
  int drops_a = 0;

  // Reference model: pending bytes, session flag, timestamp of last byte.
  logic [7:0]  pend_q[$];
  int unsigned m_addr;
  bit          m_active;
  int          cyc, last_cyc;
  logic        m_valid, m_loading, m_drop;
  logic [31:0] m_data, m_word_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_addr = 0; m_active = 0; cyc = 0; last_cyc = 0;
    m_valid = 0; m_loading = 0; m_drop = 0; m_data = 0; m_word_addr = 0;
  endtask

  task automatic model_step(input logic br, input logic [7:0] bd, input logic clr);
    cyc++;
    m_valid = 0;
    m_drop  = 0;
    if (clr) begin
      pend_q.delete();
      m_addr = 0;
      m_active = 0;
    end else if (br) begin
      pend_q.push_back(bd);
      last_cyc = cyc;
      m_active = 1;
      if (pend_q.size() == 4) begin
        m_data      = {pend_q[3], pend_q[2], pend_q[1], pend_q[0]};
        m_word_addr = m_addr;
        m_addr++;
        m_valid = 1;
        pend_q.delete();
      end
    end else if (m_active && (cyc - last_cyc == T)) begin
      m_active = 0;
      m_drop   = (pend_q.size() != 0);
      pend_q.delete();
      m_addr = 0;
    end
    m_loading = m_active;
  endtask

  task automatic check_outputs();
    chk("a_valid", a_valid, m_valid);
    chk("b_valid", b_valid, m_valid);
    if (m_valid) begin
      chk("a_addr", a_addr, {16'h0, m_word_addr[15:0]});
      chk("b_addr", b_addr, {30'h0, m_word_addr[1:0]});
    end
    chk("a_data", a_data, m_data);
    chk("b_data", b_data, m_data);
    chk("a_loading", a_loading, m_loading);
    chk("b_loading", b_loading, m_loading);
    chk("a_drop", a_drop, m_drop);
    chk("b_drop", b_drop, m_drop);
    chk("a_excl", a_valid & a_drop, 0);
    words_a += int'(a_valid);
    drops_a += int'(a_drop);
  endtask

  // One clock: drive inputs, advance model, sample just after the edge.
  task automatic step(input logic br, input logic [7:0] bd, input logic clr);
    byte_ready = br;
    byte_data  = bd;
    clear      = clr;
    model_step(br, bd, clr);
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic        br;
    logic [7:0]  bd;
    logic        clr;
    logic        ev;
    logic [15:0] ea;
    logic [31:0] ed;
    logic        el;
    logic        edr;
  } vec_t;

  vec_t vt[13];

  initial begin
    int w0, d0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 16'h0, 32'h0,        1'b1, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 16'h0, 32'h0,        1'b1, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 16'h0, 32'h0,        1'b1, 1'b0};
    vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 16'h0, 32'h44332211, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 32'h44332211, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 16'h0, 32'h44332211, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 8'h66, 1'b0, 1'b0, 16'h0, 32'h44332211, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 16'h0, 32'h44332211, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 8'h88, 1'b0, 1'b0, 16'h0, 32'h44332211, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 8'h99, 1'b0, 1'b0, 16'h0, 32'h44332211, 1'b1, 1'b0};
    vt[10] = '{1'b1, 8'hAA, 1'b0, 1'b0, 16'h0, 32'h44332211, 1'b1, 1'b0};
    vt[11] = '{1'b1, 8'hBB, 1'b0, 1'b1, 16'h0, 32'hBBAA9988, 1'b1, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 32'hBBAA9988, 1'b1, 1'b0};

    // Clock/reset.
    reset_n = 1'b0; byte_ready = 1'b0; byte_data = 8'h00; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_data", a_data, 0);
    chk("rst_loading", a_loading, 0);
    chk("rst_drop", a_drop, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Vector table: first word, clear on a 3rd byte, restart at address 0.
    for (int i = 0; i < 13; i++) begin
      step(vt[i].br, vt[i].bd, vt[i].clr);
      chk($sformatf("vec%0d_valid", i), a_valid, vt[i].ev);
      if (vt[i].ev) chk($sformatf("vec%0d_addr", i), a_addr, vt[i].ea);
      chk($sformatf("vec%0d_data", i), a_data, vt[i].ed);
      chk($sformatf("vec%0d_loading", i), a_loading, vt[i].el);
      chk($sformatf("vec%0d_drop", i), a_drop, vt[i].edr);
    end
    idle(T + 2);
    chk("full_word_end_no_drop", drops_a, 0);

    // Two words, timeout, new session restarts at address 0.
    w0 = words_a;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
    idle(T + 3);
    chk("seqA_loading_fell", a_loading, 0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    step(1'b1, 8'hDD, 1'b0);
    chk("seqA_valid", a_valid, 1);
    chk("seqA_addr", a_addr, 0);
    chk("seqA_data", a_data, 32'hDDCCBBAA);
    chk("seqA_words", words_a - w0, 3);
    idle(T + 2);

    // Partial word then silence: exactly one drop pulse, address back to 0.
    w0 = words_a; d0 = drops_a;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    idle(T + 2);
    chk("partial_drops", drops_a - d0, 1);
    chk("partial_words", words_a - w0, 0);
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    chk("partial_next_addr", a_addr, 0);
    chk("partial_next_data", a_data, 32'h40302010);
    idle(T + 2);

    // Byte exactly on the expiry cycle keeps the session alive.
    d0 = drops_a;
    step(1'b1, 8'h5A, 1'b0);
    idle(T - 1);
    step(1'b1, 8'h5B, 1'b0);
    chk("collide_loading", a_loading, 1);
    step(1'b1, 8'h5C, 1'b0);
    step(1'b1, 8'h5D, 1'b0);
    chk("collide_valid", a_valid, 1);
    chk("collide_data", a_data, 32'h5D5C5B5A);
    chk("collide_drops", drops_a - d0, 0);
    idle(T + 2);

    // 20 bytes in one session: 2-bit address wraps.
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      if (b_valid) got_q.push_back(b_addr);
    end
    chk("wrap_count", got_q.size(), exp_q.size());
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) chk($sformatf("wrap_addr%0d", i), got_q[i], exp_q[i]);
    end
    idle(T + 2);

    // Randomized traffic with clears and near-timeout silences.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
      else if (r < 7) idle($urandom_range(T - 2, T + 2));
      else step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
    end
    idle(T + 2);

    // Asynchronous reset mid-word.
    step(1'b1, 8'hE1, 1'b0);
    step(1'b1, 8'hE2, 1'b0);
    step(1'b1, 8'hE3, 1'b0);
    byte_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("amid_valid", a_valid, 0);
    chk("amid_addr", a_addr, 0);
    chk("amid_data", a_data, 0);
    chk("amid_loading", a_loading, 0);
    chk("amid_drop", a_drop, 0);
    chk("amid_b_data", b_data, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    idle(T + 3);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'hF1, 1'b0);
    step(1'b1, 8'hF2, 1'b0);
    step(1'b1, 8'hF3, 1'b0);
    chk("post_rst_addr", a_addr, 0);
    chk("post_rst_data", a_data, 32'hF3F2F1F0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
